// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg
// Shared definitions for the mux_pipe selector stage:
//   - state encoding for the two-entry skid register (EMPTY / ONE / FULL)
//   - MUX_PIPE_DEFAULT_ALL_ONES: fill bit for the out-of-range default word
package mux_pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      EMPTY = ST_EMPTY,
      ONE   = ST_ONE,
      FULL  = ST_FULL
   } mux_pipe_state_t;

   localparam logic MUX_PIPE_DEFAULT_ALL_ONES = 1'b1;

endpackage

// File: rtl/mux_pipe_skid_reg.sv
// skid_reg
// Two-entry skid-buffered pipeline register with valid/ready handshake.
// Main register drives out_data; skid register absorbs one word when the
// downstream stalls, so in_ready can be a flop with no path from out_ready.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   in_data [B]           word offered upstream
//   out_valid / out_ready downstream handshake (out_valid registered)
//   out_data [B]          main register contents
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no word held; out_valid=0, in_ready=1
// ONE   | main holds a word; out_valid=1, in_ready=1
// FULL  | main and skid hold words; out_valid=1, in_ready=0
module skid_reg #(
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [B-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [B-1:0] out_data
);
   import mux_pipe_pkg::*;

   mux_pipe_state_t state_q, state_d;
   logic [B-1:0]    main_q, main_d;
   logic [B-1:0]    skid_q, skid_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            in_xfer;
   logic            out_xfer;

   always_comb begin
      in_xfer  = in_valid && in_ready_q;
      out_xfer = out_valid_q && out_ready;
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (out_xfer && !in_xfer) begin
               state_d = EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_d = in_data;
            end
         end
         FULL: begin
            // in_ready is low here, so only a drain can happen
            if (out_xfer) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // handshake flags are registered copies of the next-state decode
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe
// N-way, B-bit selector feeding a two-entry skid-buffered pipeline stage.
// sel >= N selects DEFAULT (only reachable when N is not a power of two).
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   sel [SW]              item index
//   items [N*B]           flattened inputs, item k = items[k*B +: B]
//   out_valid / out_ready downstream handshake
//   signal [B]            selected word, registered
//   err                   sticky out-of-range flag
//
// Build option MUX_PIPE_ERR_EN: when defined, err latches on any accepted
// transfer with sel >= N until reset; when undefined, err is tied low.
module mux_pipe
   import mux_pipe_pkg::*;
#(
   parameter  int         B       = 32,
   parameter  int         N       = 4,
   localparam int         SW      = $clog2(N),
   parameter  logic [B-1:0] DEFAULT = {B{MUX_PIPE_DEFAULT_ALL_ONES}}
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [SW-1:0]  sel,
   input  logic [N*B-1:0] items,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [B-1:0]   signal,
   output logic           err
);

   logic [B-1:0] word;

   always_comb begin
      word = DEFAULT;
      for (int k = 0; k < N; k++) begin
         if (sel == SW'(k)) word = items[k*B +: B];
      end
   end

   skid_reg #(
      .B (B)
   ) u_skid_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (signal)
   );

`ifdef MUX_PIPE_ERR_EN
   logic err_q, err_d;
   logic sel_oor;

   always_comb begin
      sel_oor = (32'(sel) >= 32'(N));
      err_d   = err_q | (in_valid & in_ready & sel_oor);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
